// File: rtl/seq101_pkg.sv
// Shared types and constants for the "101" serial frame transmitter.
package seq101_pkg;

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} tx_state_t;

    localparam logic [2:0] PREAMBLE = 3'b101;
    localparam int         PRE_LEN  = 3;

    // Preamble is sent MSB first, so index 0 selects bit 2.
    function automatic logic preamble_bit(input logic [1:0] idx);
        return PREAMBLE[2'd2 - idx];
    endfunction

endpackage

// File: rtl/seq101_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload MSB first, optional even parity, low gap.
module seq101_tx
    import seq101_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_active,
    output logic              frame_done
);

    localparam int CNT_MAX_A = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
    localparam int CNT_MAX   = (GAP_LEN > CNT_MAX_A) ? GAP_LEN : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam tx_state_t AFTER_PAR  = (GAP_LEN > 0) ? GAP : IDLE;
    localparam tx_state_t AFTER_DATA = (PARITY_EN != 0) ? PAR : AFTER_PAR;

    if (DATA_W < 1) begin : g_bad_data_w
        $error("seq101_tx: DATA_W must be >= 1");
    end
    if (GAP_LEN < 0) begin : g_bad_gap_len
        $error("seq101_tx: GAP_LEN must be >= 0");
    end

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              out_q, out_d;
    logic              out_active_q, out_active_d;
    logic              frame_done_q, frame_done_d;

    assign in_ready   = (state_q == IDLE);
    assign out        = out_q;
    assign out_active = out_active_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    shift_d = in_data;
                    par_d   = ^in_data;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = AFTER_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = shift_q << 1;
                end
            end
            PAR: begin
                state_d = AFTER_PAR;
                cnt_d   = '0;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line lines up with the state.
    always_comb begin
        out_d        = 1'b0;
        out_active_d = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_d)
            PRE: begin
                out_d        = preamble_bit(cnt_d[1:0]);
                out_active_d = 1'b1;
            end
            DATA: begin
                out_d        = shift_d[DATA_W-1];
                out_active_d = 1'b1;
                frame_done_d = (PARITY_EN == 0) && (cnt_d == DATA_LAST);
            end
            PAR: begin
                out_d        = par_d;
                out_active_d = 1'b1;
                frame_done_d = 1'b1;
            end
            default: begin
                out_d        = 1'b0;
                out_active_d = 1'b0;
                frame_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            out_q        <= 1'b0;
            out_active_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            out_q        <= out_d;
            out_active_q <= out_active_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
